// File: rtl/lite_mem_pkg.sv
// Shared definitions for the LITE data memory: RV32I funct3 size codes, FSM states, word width.
package lite_mem_pkg;
   localparam int WORD_W = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } memState_e;
endpackage

// File: rtl/lite_mem_align.sv
// Combinational RV32I sizing: store lane merge/mask, load lane select/extension, bad-request flag.
// With MISALIGN_TRAP_EN defined, misaligned H/HU/SH and W/SW accesses are flagged as bad.
module lite_mem_align
   import lite_mem_pkg::*;
(
   input  logic [2:0]        funct3,
   input  logic              isStore,
   input  logic [1:0]        lane,
   input  logic [WORD_W-1:0] storeData,
   input  logic [WORD_W-1:0] rdWord,
   output logic [3:0]        wrMask,
   output logic [WORD_W-1:0] wrLanes,
   output logic [WORD_W-1:0] loadData,
   output logic              bad
);
   logic [7:0]  byteSel;
   logic [15:0] halfSel;
   logic        illegal;

   // Halfwords always use the lane pair chosen by lane[1]; lane[0] only matters for trapping.
   assign byteSel = 8'(rdWord >> {lane, 3'b000});
   assign halfSel = 16'(rdWord >> {lane[1], 4'b0000});

   always_comb begin
      wrMask   = '0;
      wrLanes  = '0;
      loadData = '0;
      illegal  = 1'b0;
      case (funct3)
         F3_B, F3_BU: begin
            wrMask   = 4'b0001 << lane;
            wrLanes  = {4{storeData[7:0]}};
            loadData = (funct3 == F3_B) ? {{24{byteSel[7]}}, byteSel} : {24'b0, byteSel};
            illegal  = isStore && (funct3 == F3_BU);
         end
         F3_H, F3_HU: begin
            wrMask   = 4'b0011 << {lane[1], 1'b0};
            wrLanes  = {2{storeData[15:0]}};
            loadData = (funct3 == F3_H) ? {{16{halfSel[15]}}, halfSel} : {16'b0, halfSel};
            illegal  = isStore && (funct3 == F3_HU);
         end
         F3_W: begin
            wrMask   = 4'b1111;
            wrLanes  = storeData;
            loadData = rdWord;
         end
         default: illegal = 1'b1;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic misalign;
   assign misalign = (((funct3 == F3_H) || (funct3 == F3_HU)) && lane[0]) ||
                     ((funct3 == F3_W) && (lane != 2'b00));
   assign bad = illegal || misalign;
`else
   assign bad = illegal;
`endif
endmodule

// File: rtl/lite_datamem_ws.sv
// Word-organised data memory with programmable wait states and ready/err response handshake.
// Optional MISALIGN_TRAP_EN turns misaligned halfword/word accesses into error responses.
module lite_datamem_ws
   import lite_mem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter string       INIT_FILE   = ""
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              datamem_enable,
   input  logic [WORD_W-1:0] datamem_address,
   input  logic [WORD_W-1:0] datamem_datain,
   input  logic              datamem_negread_write,
   input  logic [2:0]        funct3,
   output logic [WORD_W-1:0] datamem_dataout,
   output logic              datamem_ready,
   output logic              datamem_err
);
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   memState_e         state;
   logic [3:0]        waitCnt;
   logic [WORD_W-1:0] reqAddr, reqData;
   logic              reqWrite;
   logic [2:0]        reqF3;
   logic [3:0][7:0]   mem [DEPTH];

   logic                  below, outOfRange, alignBad, reqBad, accept, doWrite;
   logic [WORD_W-1:0]     off, wrLanes, loadData;
   logic [DEPTH_LOG2-1:0] wordIdx;
   logic [3:0]            wrMask;

   // Borrow out of the subtraction marks addresses below the window.
   assign {below, off} = {1'b0, reqAddr} - {1'b0, BASE_ADDR};
   assign outOfRange   = below || ((off >> (DEPTH_LOG2 + 2)) != '0);
   assign wordIdx      = off[DEPTH_LOG2+1:2];
   assign reqBad       = outOfRange || alignBad;
   assign accept       = datamem_enable && ((state == IDLE) || (state == RESP));
   assign doWrite      = (state == RESP) && reqWrite && !reqBad;

   lite_mem_align uAlign (
      .funct3    (reqF3),
      .isStore   (reqWrite),
      .lane      (off[1:0]),
      .storeData (reqData),
      .rdWord    (mem[wordIdx]),
      .wrMask    (wrMask),
      .wrLanes   (wrLanes),
      .loadData  (loadData),
      .bad       (alignBad)
   );

   // The access executes during RESP; its result is registered on the edge leaving RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         waitCnt         <= '0;
         reqAddr         <= '0;
         reqData         <= '0;
         reqWrite        <= 1'b0;
         reqF3           <= '0;
         datamem_dataout <= '0;
         datamem_ready   <= 1'b0;
         datamem_err     <= 1'b0;
      end else begin
         datamem_ready   <= (state == RESP);
         datamem_err     <= (state == RESP) && reqBad;
         datamem_dataout <= ((state == RESP) && !reqBad && !reqWrite) ? loadData : '0;
         if (state == WAIT) begin
            waitCnt <= waitCnt - 4'd1;
            if (waitCnt == 4'd1) state <= RESP;
         end else if (accept) begin
            reqAddr  <= datamem_address;
            reqData  <= datamem_datain;
            reqWrite <= datamem_negread_write;
            reqF3    <= funct3;
            if (WAIT_STATES > 0) begin
               state   <= WAIT;
               waitCnt <= 4'(WAIT_STATES);
            end else begin
               state <= RESP;
            end
         end else begin
            state <= IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (doWrite) begin
         for (int b = 0; b < 4; b++) begin
            if (wrMask[b]) mem[wordIdx][b] <= wrLanes[8*b +: 8];
         end
      end
   end
endmodule
